fetch_queue_stage: RTL and testbench

Parametrised instruction-fetch stage. Owns the PC, issues reads to a synchronous instruction memory port, and buffers returned instructions with their PC and PC+4 in a small FIFO. Decode drains the FIFO through a valid/ready handshake. Later-stage jumps and branches redirect the PC, which flushes buffered and in-flight fetches; there is no separate negedge/posedge fetch register.

---
 rtl/fetch_queue_stage.sv | 112 +++++++++++
 tb/tb_fetch_queue_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_stage.sv
// Instruction-fetch stage: owns the PC, issues reads to a synchronous
// instruction memory, and queues {instr, pc, pc+4} for decode.
module fetch_queue_stage #(
    parameter int                XLEN         = 32,
    parameter int                ADDR_BITS    = 14,
    parameter int                QUEUE_DEPTH  = 4,
    parameter logic [XLEN-1:0]   RESET_VECTOR = 32'h0000_0000
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic                 REDIRECT_VALID,
    input  logic [XLEN-1:0]      REDIRECT_PC,
    output logic [ADDR_BITS-1:0] MEM_ADDR1,
    output logic                 MEM_RDEN1,
    input  logic [XLEN-1:0]      MEM_DOUT1,
    output logic                 FETCH_VALID,
    input  logic                 FETCH_READY,
    output logic [XLEN-1:0]      FETCH_IR,
    output logic [XLEN-1:0]      FETCH_PC,
    output logic [XLEN-1:0]      FETCH_PC_4,
    output logic [4:0]           FETCH_COUNT
);

    localparam int          PTR_W   = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam logic [5:0]  DEPTH_C = 6'(QUEUE_DEPTH);

    logic [XLEN-1:0]  pc_r;
    logic [XLEN-1:0]  issued_pc_r;
    logic             inflight_r;
    logic [4:0]       count_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [XLEN-1:0]  ir_mem_r  [QUEUE_DEPTH];
    logic [XLEN-1:0]  pc_mem_r  [QUEUE_DEPTH];
    logic [XLEN-1:0]  pc4_mem_r [QUEUE_DEPTH];

    logic             valid_s;
    logic             pop_s;
    logic             push_s;
    logic             issue_s;
    logic [5:0]       credit_s;
    logic             unused_s;

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QUEUE_DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    // Handshake, credit and issue decisions for the current cycle.
    always_comb begin
        valid_s  = (count_r != 5'd0);
        pop_s    = valid_s & FETCH_READY & ~REDIRECT_VALID;
        push_s   = inflight_r & ~REDIRECT_VALID;
        // Credit counts the response still on its way so a push can never overflow.
        credit_s = {1'b0, count_r} + {5'd0, inflight_r} - {5'd0, pop_s};
        issue_s  = ~RESET & ~REDIRECT_VALID & (credit_s < DEPTH_C);
        unused_s = ^REDIRECT_PC[1:0];
    end

    // PC, in-flight tracking, pointers and occupancy.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            pc_r        <= RESET_VECTOR;
            issued_pc_r <= RESET_VECTOR;
            inflight_r  <= 1'b0;
            count_r     <= 5'd0;
            rd_ptr_r    <= {PTR_W{1'b0}};
            wr_ptr_r    <= {PTR_W{1'b0}};
        end else if (REDIRECT_VALID) begin
            pc_r        <= {REDIRECT_PC[XLEN-1:2], 2'b00};
            inflight_r  <= 1'b0;
            count_r     <= 5'd0;
            rd_ptr_r    <= {PTR_W{1'b0}};
            wr_ptr_r    <= {PTR_W{1'b0}};
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                pc_r        <= pc_r + XLEN'(4);
                issued_pc_r <= pc_r;
            end
            if (push_s) begin
                wr_ptr_r <= ptr_next(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 5'd1;
                2'b01:   count_r <= count_r - 5'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Queue storage; datapath only, occupancy is tracked above.
    always_ff @(posedge CLOCK) begin
        if (push_s && !RESET) begin
            ir_mem_r[wr_ptr_r]  <= MEM_DOUT1;
            pc_mem_r[wr_ptr_r]  <= issued_pc_r;
            pc4_mem_r[wr_ptr_r] <= issued_pc_r + XLEN'(4);
        end
    end

    assign MEM_ADDR1   = pc_r[ADDR_BITS+1:2];
    assign MEM_RDEN1   = issue_s;
    assign FETCH_VALID = valid_s;
    assign FETCH_COUNT = count_r;
    assign FETCH_IR    = valid_s ? ir_mem_r[rd_ptr_r]  : {XLEN{1'b0}};
    assign FETCH_PC    = valid_s ? pc_mem_r[rd_ptr_r]  : {XLEN{1'b0}};
    assign FETCH_PC_4  = valid_s ? pc4_mem_r[rd_ptr_r] : {XLEN{1'b0}};

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Self-checking bench for fetch_queue_stage: directed scenarios followed by
// randomized traffic checked against an in-order program-counter model.
module tb_fetch_queue_stage;

    logic        CLOCK;
    logic        RESET;
    logic        REDIRECT_VALID;
    logic [31:0] REDIRECT_PC;
    logic [13:0] MEM_ADDR1;
    logic        MEM_RDEN1;
    logic [31:0] MEM_DOUT1;
    logic        FETCH_VALID;
    logic        FETCH_READY;
    logic [31:0] FETCH_IR;
    logic [31:0] FETCH_PC;
    logic [31:0] FETCH_PC_4;
    logic [4:0]  FETCH_COUNT;

    int n_checks;
    int n_fail;

    fetch_queue_stage dut (
        .CLOCK          (CLOCK),
        .RESET          (RESET),
        .REDIRECT_VALID (REDIRECT_VALID),
        .REDIRECT_PC    (REDIRECT_PC),
        .MEM_ADDR1      (MEM_ADDR1),
        .MEM_RDEN1      (MEM_RDEN1),
        .MEM_DOUT1      (MEM_DOUT1),
        .FETCH_VALID    (FETCH_VALID),
        .FETCH_READY    (FETCH_READY),
        .FETCH_IR       (FETCH_IR),
        .FETCH_PC       (FETCH_PC),
        .FETCH_PC_4     (FETCH_PC_4),
        .FETCH_COUNT    (FETCH_COUNT)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    // Synchronous instruction memory: word[n] = A000_0000 + n.
    always @(posedge CLOCK) begin
        if (MEM_RDEN1) MEM_DOUT1 <= 32'hA000_0000 + {18'd0, MEM_ADDR1};
    end

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return 32'hA000_0000 + {18'd0, pc[15:2]};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    // Leaves the bench at the start of cycle 0 (first cycle with RESET low).
    task automatic reset_dut();
        RESET          = 1'b1;
        REDIRECT_VALID = 1'b0;
        REDIRECT_PC    = 32'd0;
        tick();
        tick();
        @(negedge CLOCK);
        check_eq("rst_valid", {31'd0, FETCH_VALID}, 32'd0);
        check_eq("rst_count", {27'd0, FETCH_COUNT}, 32'd0);
        check_eq("rst_rden",  {31'd0, MEM_RDEN1},   32'd0);
        check_eq("rst_ir",    FETCH_IR,             32'd0);
        tick();
        RESET = 1'b0;
    endtask

    task automatic expect_head(input string tag, input logic [31:0] pc);
        check_eq({tag, "_valid"}, {31'd0, FETCH_VALID}, 32'd1);
        check_eq({tag, "_pc"},    FETCH_PC,             pc);
        check_eq({tag, "_pc4"},   FETCH_PC_4,           pc + 32'd4);
        check_eq({tag, "_ir"},    FETCH_IR,             word_at(pc));
    endtask

    logic [31:0] exp_pc;
    logic [31:0] tgt;

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        RESET          = 1'b1;
        REDIRECT_VALID = 1'b0;
        REDIRECT_PC    = 32'd0;
        FETCH_READY    = 1'b0;

        // Streaming: one instruction per cycle from cycle 2.
        FETCH_READY = 1'b1;
        reset_dut();
        for (int k = 0; k < 10; k++) begin
            @(negedge CLOCK);
            check_eq("str_rden", {31'd0, MEM_RDEN1}, 32'd1);
            if (k == 0) check_eq("str_addr0", {18'd0, MEM_ADDR1}, 32'd0);
            if (k < 2) begin
                check_eq("str_lat", {31'd0, FETCH_VALID}, 32'd0);
            end else begin
                expect_head("str", 32'(4 * (k - 2)));
                check_eq("str_count", {27'd0, FETCH_COUNT}, 32'd1);
            end
            tick();
        end

        // Backpressure: fill to depth, then drain without gaps.
        FETCH_READY = 1'b0;
        reset_dut();
        for (int k = 0; k < 8; k++) begin
            @(negedge CLOCK);
            if (k == 3) check_eq("bp_rden3", {31'd0, MEM_RDEN1}, 32'd1);
            if (k >= 4) check_eq("bp_rden_off", {31'd0, MEM_RDEN1}, 32'd0);
            if (k == 7) begin
                check_eq("bp_count", {27'd0, FETCH_COUNT}, 32'd4);
                check_eq("bp_addr",  {18'd0, MEM_ADDR1},   32'd4);
                expect_head("bp_hold", 32'd0);
            end
            tick();
        end
        FETCH_READY = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge CLOCK);
            expect_head("drain", 32'(4 * k));
            tick();
        end

        // Redirect with two buffered entries, a returning response and READY=1.
        reset_dut();
        FETCH_READY = 1'b1;
        tick();
        tick();
        FETCH_READY = 1'b0;
        tick();
        @(negedge CLOCK);
        check_eq("rd_pre_count", {27'd0, FETCH_COUNT}, 32'd2);
        #1;
        FETCH_READY    = 1'b1;
        REDIRECT_VALID = 1'b1;
        REDIRECT_PC    = 32'h0000_0203;
        #1;
        check_eq("rd_rden_cyc", {31'd0, MEM_RDEN1}, 32'd0);
        tick();
        REDIRECT_VALID = 1'b0;
        @(negedge CLOCK);
        check_eq("rd_valid1", {31'd0, FETCH_VALID}, 32'd0);
        check_eq("rd_count1", {27'd0, FETCH_COUNT}, 32'd0);
        check_eq("rd_addr",   {18'd0, MEM_ADDR1},   32'h80);
        check_eq("rd_rden1",  {31'd0, MEM_RDEN1},   32'd1);
        tick();
        @(negedge CLOCK);
        check_eq("rd_valid2", {31'd0, FETCH_VALID}, 32'd0);
        tick();
        @(negedge CLOCK);
        expect_head("rd_first", 32'h200);
        tick();
        @(negedge CLOCK);
        expect_head("rd_second", 32'h204);

        // PC wrap at the top of the address space.
        #1;
        REDIRECT_VALID = 1'b1;
        REDIRECT_PC    = 32'hFFFF_FFFF;
        tick();
        REDIRECT_VALID = 1'b0;
        tick();
        tick();
        @(negedge CLOCK);
        expect_head("wrap_top", 32'hFFFF_FFFC);
        tick();
        @(negedge CLOCK);
        expect_head("wrap_zero", 32'h0);
        tick();

        // Reset mid-operation with three entries and one response in flight.
        FETCH_READY = 1'b0;
        reset_dut();
        for (int k = 0; k < 4; k++) tick();
        @(negedge CLOCK);
        check_eq("mr_pre_count", {27'd0, FETCH_COUNT}, 32'd3);
        RESET = 1'b1;
        tick();
        @(negedge CLOCK);
        check_eq("mr_valid", {31'd0, FETCH_VALID}, 32'd0);
        check_eq("mr_count", {27'd0, FETCH_COUNT}, 32'd0);
        check_eq("mr_rden",  {31'd0, MEM_RDEN1},   32'd0);
        tick();
        RESET       = 1'b0;
        FETCH_READY = 1'b1;
        tick();
        tick();
        @(negedge CLOCK);
        expect_head("mr_first", 32'h0);
        tick();

        // Randomized traffic: decode must see consecutive PCs from the last
        // reset/redirect target, with matching instruction words.
        reset_dut();
        exp_pc = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            RESET          = ($urandom % 200) == 0;
            REDIRECT_VALID = ($urandom % 30) == 0;
            tgt            = $urandom;
            if (($urandom % 6) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
            REDIRECT_PC    = tgt;
            FETCH_READY    = ($urandom % 4) != 0;
            @(negedge CLOCK);
            if (RESET || REDIRECT_VALID)
                check_eq("rnd_rden_block", {31'd0, MEM_RDEN1}, 32'd0);
            check_eq("rnd_count_max", {31'd0, (FETCH_COUNT <= 5'd4)}, 32'd1);
            if (!FETCH_VALID) begin
                check_eq("rnd_empty_ir", FETCH_IR, 32'd0);
                check_eq("rnd_empty_pc", FETCH_PC, 32'd0);
            end
            if (RESET) begin
                exp_pc = 32'h0;
            end else if (REDIRECT_VALID) begin
                exp_pc = tgt & 32'hFFFF_FFFC;
            end else if (FETCH_VALID && FETCH_READY) begin
                check_eq("rnd_pc",  FETCH_PC,   exp_pc);
                check_eq("rnd_pc4", FETCH_PC_4, exp_pc + 32'd4);
                check_eq("rnd_ir",  FETCH_IR,   word_at(exp_pc));
                exp_pc = exp_pc + 32'd4;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
